// File: rtl/img_loader.sv
// Frame loader: accepts a raster-ordered greyscale stream and writes it into a frame buffer.
// Define IMG_LOADER_SOF_CHK_EN to compile in start-of-frame framing checks on s_sof.
module img_loader #(
  parameter int unsigned IMG_WD     = 5,
  parameter int unsigned IMG_HT     = 5,
  parameter int unsigned COORD_BITS = 3,
  parameter int unsigned PXL_BITS   = 13,
  parameter int unsigned IN_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_BITS-1:0]    s_data,
  input  logic                  s_sof,
  output logic                  wr_en,
  output logic [COORD_BITS-1:0] wr_x,
  output logic [COORD_BITS-1:0] wr_y,
  output logic [PXL_BITS-1:0]   wr_data_pxl,
  output logic                  busy,
  output logic                  load_done,
  output logic                  frame_err
);

  localparam logic [COORD_BITS-1:0] XMax = COORD_BITS'(IMG_WD - 1);
  localparam logic [COORD_BITS-1:0] YMax = COORD_BITS'(IMG_HT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                state_q, state_d;
  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d;
  logic                  wr_en_q, wr_en_d;
  logic [COORD_BITS-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [PXL_BITS-1:0]   wr_data_q, wr_data_d;
  logic                  load_done_q, load_done_d;
  logic                  frame_err_q, frame_err_d;

  // Coordinates the current beat lands on, and whether it is written at all.
  logic [COORD_BITS-1:0] beat_x, beat_y;
  logic                  do_write;

`ifndef IMG_LOADER_SOF_CHK_EN
  logic unused_sof;
  assign unused_sof = s_sof;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    wr_en_d     = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_data_d   = wr_data_q;
    load_done_d = load_done_q;
    frame_err_d = frame_err_q;
    beat_x      = x_q;
    beat_y      = y_q;
    do_write    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          state_d     = StLoad;
          x_d         = '0;
          y_d         = '0;
          load_done_d = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      StLoad: begin
        if (s_valid) begin
          do_write = 1'b1;
`ifdef IMG_LOADER_SOF_CHK_EN
          if (s_sof && (x_q != '0 || y_q != '0)) begin
            // Unexpected start of frame: restart the frame at the origin.
            frame_err_d = 1'b1;
            beat_x      = '0;
            beat_y      = '0;
          end else if (!s_sof && x_q == '0 && y_q == '0) begin
            frame_err_d = 1'b1;
            do_write    = 1'b0;
          end
`endif
          if (do_write) begin
            wr_en_d   = 1'b1;
            wr_x_d    = beat_x;
            wr_y_d    = beat_y;
            wr_data_d = PXL_BITS'(s_data);
            if (beat_x == XMax) begin
              x_d = '0;
              if (beat_y == YMax) begin
                y_d         = '0;
                state_d     = StDone;
                load_done_d = 1'b1;
              end else begin
                y_d = beat_y + COORD_BITS'(1);
              end
            end else begin
              x_d = beat_x + COORD_BITS'(1);
              y_d = beat_y;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_data_q   <= '0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_en_q     <= wr_en_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_data_q   <= wr_data_d;
      load_done_q <= load_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign s_ready     = (state_q == StLoad);
  assign busy        = (state_q == StLoad);
  assign wr_en       = wr_en_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign wr_data_pxl = wr_data_q;
  assign load_done   = load_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader: directed frames plus random traffic against a
// linear-pixel-index reference model. SOF framing scenarios run when IMG_LOADER_SOF_CHK_EN is set.
module tb_img_loader;

  localparam int W = 5;
  localparam int H = 5;

  logic        clk;
  logic        rst;
  logic        load;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_sof;
  logic        wr_en;
  logic [2:0]  wr_x;
  logic [2:0]  wr_y;
  logic [12:0] wr_data_pxl;
  logic        busy;
  logic        load_done;
  logic        frame_err;

  img_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data_pxl (wr_data_pxl),
    .busy        (busy),
    .load_done   (load_done),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int wr_cnt   = 0;

  // Reference model: frame position as a linear pixel index.
  int m_state = 0;  // 0 idle, 1 loading, 2 done
  int m_pos   = 0;
  int m_wr_en = 0;
  int m_wx    = 0;
  int m_wy    = 0;
  int m_wd    = 0;
  int m_done  = 0;
  int m_err   = 0;

  logic [7:0] vals [0:63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit l, input bit v, input logic [7:0] d, input bit s);
    int  wpos;
    bit  wr;
    if (r) begin
      m_state = 0; m_pos = 0; m_wr_en = 0; m_wx = 0; m_wy = 0; m_wd = 0;
      m_done = 0; m_err = 0;
      return;
    end
    m_wr_en = 0;
    if (m_state != 1) begin
      if (l) begin
        m_state = 1; m_pos = 0; m_done = 0; m_err = 0;
      end
    end else if (v) begin
      wpos = m_pos;
      wr   = 1'b1;
`ifdef IMG_LOADER_SOF_CHK_EN
      if (s && m_pos != 0) begin
        m_err = 1; wpos = 0;
      end else if (!s && m_pos == 0) begin
        m_err = 1; wr = 1'b0;
      end
`else
      if (s) wr = 1'b1;
`endif
      if (wr) begin
        m_wr_en = 1;
        m_wx    = wpos % W;
        m_wy    = wpos / W;
        m_wd    = int'(d);
        m_pos   = wpos + 1;
        if (m_pos == W * H) begin
          m_state = 2; m_done = 1; m_pos = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit v, input logic [7:0] d, input bit s);
    @(negedge clk);
    rst = r; load = l; s_valid = v; s_data = d; s_sof = s;
    @(posedge clk);
    model(r, l, v, d, s);
    #1;
    check("s_ready", 32'(s_ready), 32'(m_state == 1));
    check("busy", 32'(busy), 32'(m_state == 1));
    check("wr_en", 32'(wr_en), m_wr_en);
    check("wr_x", 32'(wr_x), m_wx);
    check("wr_y", 32'(wr_y), m_wy);
    check("wr_data_pxl", 32'(wr_data_pxl), m_wd);
    check("load_done", 32'(load_done), m_done);
`ifdef IMG_LOADER_SOF_CHK_EN
    check("frame_err", 32'(frame_err), m_err);
`else
    check("frame_err", 32'(frame_err), 32'd0);
`endif
    if (wr_en === 1'b1) wr_cnt++;
  endtask

  // Stream n beats from vals[]; sof asserted on beats sof_a and sof_b; optional load at load_at.
  task automatic stream(input int n, input bit gaps, input int sof_a, input int sof_b,
                        input int load_at);
    int k = 0;
    for (int c = 0; c < 1000 && k < n; c++) begin
      bit v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v) begin
        step(1'b0, (k == load_at), 1'b1, vals[k], (k == sof_a) || (k == sof_b));
        k++;
      end else begin
        step(1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    check("stream_beats", k, n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1);
    idle(2);

    // Back-to-back frame of values 0..24.
    for (int i = 0; i < 64; i++) vals[i] = 8'(i);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    wr_cnt = 0;
    stream(W * H, 1'b0, 0, -1, -1);
    check("frame1_writes", wr_cnt, W * H);
    check("frame1_done", 32'(load_done), 32'd1);
    idle(3);

    // Gapped frame with 255 at (2,3).
    for (int i = 0; i < 64; i++) vals[i] = 8'($urandom);
    vals[3 * W + 2] = 8'hFF;
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    wr_cnt = 0;
    stream(W * H, 1'b1, 0, -1, -1);
    idle(2);
    check("frame2_writes", wr_cnt, W * H);

    // Reset after 10 beats, then reload from the origin.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    stream(10, 1'b0, 0, -1, -1);
    step(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    stream(3, 1'b0, 0, -1, -1);
    check("reload_x", 32'(wr_x), 32'd2);

    // Load pulse during LOAD at beat 12 must be ignored.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    stream(13, 1'b0, 0, -1, 12);
    check("ignored_load_x", 32'(wr_x), 32'd2);
    check("ignored_load_y", 32'(wr_y), 32'd2);
    stream(1, 1'b0, -1, -1, -1);
    check("after_load_x", 32'(wr_x), 32'd3);
    check("after_load_y", 32'(wr_y), 32'd2);
    stream(W * H - 14, 1'b0, -1, -1, -1);
    check("frame3_done", 32'(load_done), 32'd1);
    idle(2);

`ifdef IMG_LOADER_SOF_CHK_EN
    // SOF on beat 7 restarts the frame.
    for (int i = 0; i < 64; i++) vals[i] = 8'(i + 100);
    vals[7] = 8'd99;
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    stream(8, 1'b0, 0, 7, -1);
    check("sof_err", 32'(frame_err), 32'd1);
    check("sof_x", 32'(wr_x), 32'd0);
    check("sof_data", 32'(wr_data_pxl), 32'd99);
    stream(W * H - 1, 1'b0, -1, -1, -1);
    check("sof_done", 32'(load_done), 32'd1);
    idle(2);

    // Missing SOF on first beat: discarded.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    stream(1, 1'b0, -1, -1, -1);
    check("nosof_wr_en", 32'(wr_en), 32'd0);
    check("nosof_err", 32'(frame_err), 32'd1);
    stream(1, 1'b0, 0, -1, -1);
    check("nosof_next_x", 32'(wr_x), 32'd0);
    check("nosof_next_en", 32'(wr_en), 32'd1);
    idle(2);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit r = ($urandom_range(0, 199) == 0);
      bit l = ($urandom_range(0, 24) == 0);
      bit v = ($urandom_range(0, 3) != 0);
      bit s = (m_pos == 0) ^ ($urandom_range(0, 15) == 0);
      step(r, l, v, 8'($urandom), s);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/img_loader.md
IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameter IMG_WD, default 5, image width in pixels.
REQ-002 Parameter IMG_HT, default 5, image height in pixels.
REQ-003 Parameter COORD_BITS, default 3, coordinate width (IMG_WD >= IMG_HT).
REQ-004 Parameter PXL_BITS, default 13, signed frame-buffer pixel width.
REQ-005 Parameter IN_BITS, default 8, unsigned input pixel width.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 load  input  1  single-cycle pulse; arms loading of one frame.
REQ-009 s_valid  input  1  input pixel beat valid.
REQ-010 s_ready  output  1  block accepts beat this cycle.
REQ-011 s_data  input  IN_BITS  unsigned greyscale pixel, raster order.
REQ-012 s_sof  input  1  beat is first pixel of frame.
REQ-013 wr_en  output  1  frame-buffer write strobe.
REQ-014 wr_x  output  COORD_BITS  write column.
REQ-015 wr_y  output  COORD_BITS  write row.
REQ-016 wr_data_pxl  output  PXL_BITS  write pixel.
REQ-017 busy  output  1  high while in LOAD.
REQ-018 load_done  output  1  level; frame fully written.
REQ-019 frame_err  output  1  sticky framing error flag.

Function
REQ-020 States SHALL be IDLE, LOAD, DONE; beat accepted when s_valid && s_ready.
REQ-021 s_ready SHALL be 1 only in LOAD; busy SHALL equal (state==LOAD).
REQ-022 IDLE or DONE + load=1 SHALL enter LOAD next cycle, clear x/y counters to (0,0), clear load_done and frame_err.
REQ-023 load during LOAD SHALL be ignored.
REQ-024 Each written beat SHALL produce wr_en=1 exactly one cycle after acceptance, with wr_x/wr_y = counter values at acceptance and wr_data_pxl = s_data zero-extended to PXL_BITS.
REQ-025 wr_en SHALL be 0 in every cycle not following a written beat; wr_x/wr_y/wr_data_pxl hold last value when wr_en=0.
REQ-026 After a written beat x SHALL increment; at x=IMG_WD-1, x wraps to 0 and y increments.
REQ-027 Beat written at (IMG_WD-1, IMG_HT-1) SHALL move state to DONE next cycle; s_ready=0 that cycle, load_done=1 same cycle as final wr_en.
REQ-028 load_done SHALL stay 1 in DONE until next load or rst.
REQ-029 Zero bubbles: s_valid held high SHALL load IMG_WD*IMG_HT pixels in IMG_WD*IMG_HT consecutive cycles.
REQ-030 Back-pressure from downstream does not exist; frame-buffer write always succeeds.

Reset
REQ-031 rst=1 SHALL force next cycle: state IDLE, counters (0,0), s_ready=0, wr_en=0, wr_x=0, wr_y=0, wr_data_pxl=0, busy=0, load_done=0, frame_err=0.
REQ-032 rst mid-LOAD SHALL drop any pending write (wr_en=0 following cycle); rst SHALL take priority over load and s_valid.

Configuration
REQ-033 Macro IMG_LOADER_SOF_CHK_EN SHALL compile in framing checks on s_sof.
REQ-034 With macro: accepted beat with s_sof=1 at counter != (0,0) SHALL set frame_err, be written to (0,0), and set counter to (1,0) (restart frame).
REQ-035 With macro: accepted beat with s_sof=0 at counter (0,0) SHALL set frame_err and be discarded (no wr_en, counter unchanged).
REQ-036 Without macro: s_sof SHALL be ignored, frame_err tied 0, every accepted beat written.

Verification
REQ-037 Reset then load, stream 25 beats values 0..24 back-to-back, sof on first -> 25 wr_en pulses, (x,y) raster (0,0)..(4,4), data 0..24, load_done=1 with last write, s_ready=0 after.
REQ-038 Stream 255 at (2,3) with random s_valid gaps -> wr_data_pxl=13'h0FF at (2,3), wr_en count 25, no writes during gaps.
REQ-039 With macro: sof on beat 7 (value 99) -> frame_err=1, write (0,0)=99, next beat to (1,0), done after 25 further-counted writes.
REQ-040 With macro: first beat sof=0 -> no wr_en, frame_err=1, subsequent sof beat written to (0,0).
REQ-041 rst asserted after 10 beats -> next cycle wr_en=0, busy=0, outputs zero; new load restarts at (0,0).
REQ-042 load pulse during LOAD at beat 12 -> ignored, counters continue to (3,2).
